// File: rtl/m_dm.sv
// M-stage data memory: byte/half/word stores, extended loads.
// Stores commit on the clock edge; loads and addrErr are combinational.
module m_dm #(
  parameter int DEPTH_WORDS = 3072
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        memWE,
  input  logic [2:0]  memOp,
  output logic [31:0] rdata,
  output logic        addrErr
);

  localparam int IW = $clog2(DEPTH_WORDS);
  localparam logic [31:0] LIMIT = 32'(DEPTH_WORDS * 4);

  logic [31:0]   mem_q [DEPTH_WORDS];

  logic [IW-1:0] idx;
  logic [1:0]    off;
  logic          in_rng;
  logic          is_w;
  logic          is_h;
  logic          is_b;
  logic          sx;
  logic          rsv;
  logic [31:0]   cur;
  logic [3:0]    be;
  logic [31:0]   lane;
  logic [31:0]   merged_d;
  logic [15:0]   ld_h;
  logic [7:0]    ld_b;
  logic          commit;

  assign idx    = addr[IW+1:2];
  assign off    = addr[1:0];
  assign in_rng = addr < LIMIT;
  assign cur    = in_rng ? mem_q[idx] : '0;

  always_comb begin
    is_w = 1'b0;
    is_h = 1'b0;
    is_b = 1'b0;
    sx   = 1'b0;
    rsv  = 1'b0;
    unique case (memOp)
      3'b000: is_w = 1'b1;
      3'b001: is_h = 1'b1;
      3'b010: begin
        is_h = 1'b1;
        sx   = 1'b1;
      end
      3'b011: is_b = 1'b1;
      3'b100: begin
        is_b = 1'b1;
        sx   = 1'b1;
      end
      default: rsv = 1'b1;
    endcase
  end

  assign addrErr = !in_rng || rsv
                || (is_w && off != 2'b00)
                || (is_h && off[0]);

  // Lane replication lets every byte enable pick from the same bus.
  always_comb begin
    be   = 4'b0000;
    lane = wdata;
    unique case (1'b1)
      is_w: be = 4'b1111;
      is_h: begin
        be   = off[1] ? 4'b1100 : 4'b0011;
        lane = {2{wdata[15:0]}};
      end
      is_b: begin
        be   = 4'b0001 << off;
        lane = {4{wdata[7:0]}};
      end
      default: be = 4'b0000;
    endcase
    for (int i = 0; i < 4; i++) begin
      merged_d[8*i +: 8] = be[i] ? lane[8*i +: 8] : cur[8*i +: 8];
    end
  end

  always_comb begin
    ld_h = off[1] ? cur[31:16] : cur[15:0];
    ld_b = cur[7:0];
    unique case (off)
      2'd0: ld_b = cur[7:0];
      2'd1: ld_b = cur[15:8];
      2'd2: ld_b = cur[23:16];
      2'd3: ld_b = cur[31:24];
      default: ld_b = cur[7:0];
    endcase
  end

  always_comb begin
    rdata = '0;
    if (!addrErr) begin
      unique case (1'b1)
        is_w: rdata = cur;
        is_h: rdata = {{16{sx & ld_h[15]}}, ld_h};
        is_b: rdata = {{24{sx & ld_b[7]}}, ld_b};
        default: rdata = '0;
      endcase
    end
  end

  assign commit = memWE && !addrErr;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH_WORDS; i++) begin
        mem_q[i] <= '0;
      end
    end else if (commit) begin
      mem_q[idx] <= merged_d;
`ifndef SYNTHESIS
      $display("%d@%h: *%h <= %h", $time, pc,
               {addr[31:2], 2'b00}, merged_d);
`endif
    end
  end

endmodule

// File: tb/tb_m_dm.sv
// Directed bench for m_dm with a byte-array reference model
// checked on every falling edge, plus literal expectations.
module tb_m_dm;

  logic        clk;
  logic        reset;
  logic [31:0] pc;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        memWE;
  logic [2:0]  memOp;
  logic [31:0] rdata;
  logic        addrErr;

  int checks = 0;
  int errors = 0;
  bit live = 0;

  logic [7:0] mb [0:12287];

  m_dm #(.DEPTH_WORDS(3072)) dut (
    .clk(clk),
    .reset(reset),
    .pc(pc),
    .addr(addr),
    .wdata(wdata),
    .memWE(memWE),
    .memOp(memOp),
    .rdata(rdata),
    .addrErr(addrErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h (addr %h op %0d)",
               name, act, exp, addr, memOp);
    end
  endtask

  function automatic logic m_err(input logic [31:0] a,
                                 input logic [2:0] op);
    if (a >= 32'h3000) return 1'b1;
    if (op > 3'd4) return 1'b1;
    if (op == 3'd0 && a[1:0] != 2'b00) return 1'b1;
    if ((op == 3'd1 || op == 3'd2) && a[0]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] a,
                                         input logic [2:0] op);
    int b;
    logic [15:0] h;
    logic [7:0] y;
    if (m_err(a, op)) return 32'h0;
    b = int'(a);
    h = {mb[b+1], mb[b]};
    y = mb[b];
    case (op)
      3'd0: return {mb[b+3], mb[b+2], mb[b+1], mb[b]};
      3'd1: return {16'h0, h};
      3'd2: return {{16{h[15]}}, h};
      3'd3: return {24'h0, y};
      default: return {{24{y[7]}}, y};
    endcase
  endfunction

  function automatic int m_size(input logic [2:0] op);
    if (op == 3'd0) return 4;
    if (op == 3'd1 || op == 3'd2) return 2;
    return 1;
  endfunction

  initial begin
    for (int i = 0; i < 12288; i++) mb[i] = 8'h00;
    wait (live);
    forever begin
      @(negedge clk);
      check("cmp_rdata", rdata, m_load(addr, memOp));
      check("cmp_err", {31'h0, addrErr}, {31'h0, m_err(addr, memOp)});
      @(posedge clk);
      if (reset) begin
        for (int i = 0; i < 12288; i++) mb[i] = 8'h00;
      end else if (memWE && !m_err(addr, memOp)) begin
        for (int k = 0; k < m_size(memOp); k++) begin
          mb[int'(addr) + k] = wdata[8*k +: 8];
        end
      end
    end
  end

  task automatic acc(input logic r, input logic we,
                     input logic [2:0] op, input logic [31:0] a,
                     input logic [31:0] d, input bit chk,
                     input string name, input logic [31:0] erd,
                     input logic eerr);
    reset = r;
    memWE = we;
    memOp = op;
    addr  = a;
    wdata = d;
    pc    = pc + 32'd4;
    @(negedge clk);
    if (chk) begin
      check({name, "_rd"}, rdata, erd);
      check({name, "_err"}, {31'h0, addrErr}, {31'h0, eerr});
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    pc = 32'h3000;
    reset = 1'b1;
    memWE = 1'b0;
    memOp = 3'd0;
    addr  = 32'h0;
    wdata = 32'h0;
    @(posedge clk);
    #1;
    live = 1'b1;

    acc(0, 0, 3'd0, 32'h0000, 0, 1, "rst_lw0", 32'h0, 0);
    acc(0, 0, 3'd0, 32'h2FFC, 0, 1, "rst_lwtop", 32'h0, 0);
    acc(0, 0, 3'd0, 32'h1234, 0, 1, "rst_lw1234", 32'h0, 0);

    acc(0, 1, 3'd0, 32'h0010, 32'hDEADBEEF, 1, "sw_same", 32'h0, 0);
    acc(0, 0, 3'd0, 32'h0010, 0, 1, "lw", 32'hDEADBEEF, 0);
    acc(0, 0, 3'd4, 32'h0013, 0, 1, "lb", 32'hFFFFFFDE, 0);
    acc(0, 0, 3'd3, 32'h0013, 0, 1, "lbu", 32'h000000DE, 0);
    acc(0, 0, 3'd2, 32'h0010, 0, 1, "lh", 32'hFFFFBEEF, 0);
    acc(0, 0, 3'd1, 32'h0012, 0, 1, "lhu", 32'h0000DEAD, 0);

    acc(0, 1, 3'd3, 32'h0011, 32'h000000A5, 0, "", 0, 0);
    acc(0, 0, 3'd0, 32'h0010, 0, 1, "sb_merge", 32'hDEADA5EF, 0);
    acc(0, 1, 3'd1, 32'h0012, 32'h00001234, 0, "", 0, 0);
    acc(0, 0, 3'd0, 32'h0010, 0, 1, "sh_merge", 32'h1234A5EF, 0);
    acc(0, 0, 3'd2, 32'h0012, 0, 1, "lh_pos", 32'h00001234, 0);

    acc(0, 1, 3'd0, 32'h0012, 32'hFFFFFFFF, 1, "sw_mis", 32'h0, 1);
    acc(0, 1, 3'd1, 32'h0011, 32'hFFFFFFFF, 1, "sh_mis", 32'h0, 1);
    acc(0, 1, 3'd0, 32'h3000, 32'hFFFFFFFF, 1, "sw_oor", 32'h0, 1);
    acc(0, 1, 3'd3, 32'h3000, 32'hFFFFFFFF, 1, "sb_oor", 32'h0, 1);
    acc(0, 0, 3'd0, 32'h0010, 0, 1, "unchanged", 32'h1234A5EF, 0);

    acc(0, 1, 3'd7, 32'h0020, 32'hCAFEF00D, 1, "rsv", 32'h0, 1);
    acc(0, 0, 3'd0, 32'h0020, 0, 1, "rsv_nowr", 32'h0, 0);

    acc(0, 1, 3'd3, 32'h0030, 32'h00000011, 0, "", 0, 0);
    acc(0, 1, 3'd3, 32'h0031, 32'h00000022, 0, "", 0, 0);
    acc(0, 0, 3'd0, 32'h0030, 0, 1, "b2b", 32'h00002211, 0);

    acc(0, 1, 3'd0, 32'h2FFC, 32'h89ABCDEF, 0, "", 0, 0);
    acc(0, 0, 3'd0, 32'h2FFC, 0, 1, "top_lw", 32'h89ABCDEF, 0);
    acc(0, 0, 3'd4, 32'h2FFF, 0, 1, "top_lb", 32'hFFFFFF89, 0);

    acc(0, 1, 3'd0, 32'h0044, 32'h00000001, 0, "", 0, 0);
    acc(1, 1, 3'd0, 32'h0040, 32'h55555555, 0, "", 0, 0);
    acc(0, 0, 3'd0, 32'h0040, 0, 1, "coll40", 32'h0, 0);
    acc(0, 0, 3'd0, 32'h0044, 0, 1, "coll44", 32'h0, 0);
    acc(0, 0, 3'd0, 32'h0010, 0, 1, "rst_clr", 32'h0, 0);
    acc(0, 1, 3'd0, 32'h0044, 32'h00000007, 0, "", 0, 0);
    acc(0, 0, 3'd0, 32'h0044, 0, 1, "post_rst", 32'h00000007, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
